// File: rtl/fifo_burst_reader.sv
// Burst reader: pops a synchronous FIFO and re-presents words as a valid/ready stream.
// Define FIFO_BURST_READER_STATS_EN to build the word/stall statistics counters.
module fifo_burst_reader #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [31:0]       stat_words,
    output logic [31:0]       stat_stall
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        count;
    logic              inflight;
    logic [CW-1:0]     issue_cnt;
    logic [CW-1:0]     beat_cnt;

    logic              pop;
    logic              push;
    logic [2:0]        occ;
    logic [1:0]        keep;
    logic [1:0]        count_nxt;

    assign pop  = m_valid && m_ready;
    assign push = inflight;
    assign occ  = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign keep = count - {1'b0, pop};

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
    end

    // m_ready feeds this through pop so a freed slot is refilled in the same cycle
    assign fifo_rd_en = (state == ACTIVE) && !fifo_empty && (occ < 3'd2)
                        && !(issue_cnt == '0 && !en);

    assign m_valid = (count != 2'd0);
    assign m_data  = head_q;
    assign m_last  = m_valid && (beat_cnt == LAST_IDX);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            inflight <= fifo_rd_en;
            count    <= count_nxt;

            if (pop)
                head_q <= tail_q;
            if (push) begin
                if (keep == 2'd0)
                    head_q <= fifo_rd_data;
                else
                    tail_q <= fifo_rd_data;
            end

            if (fifo_rd_en)
                issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 1'b1;
            if (pop)
                beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + 1'b1;

            case (state)
                IDLE:
                    if (en)
                        state <= ACTIVE;
                ACTIVE:
                    if (issue_cnt == '0 && !en)
                        state <= DRAIN;
                DRAIN:
                    if (count_nxt == 2'd0)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (pop)
                stat_words <= stat_words + 32'd1;
            if (m_valid && !m_ready)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`else
    assign stat_words = '0;
    assign stat_stall = '0;
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && count == 2'd2 && !pop)
    );
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (DATA_W=32, BURST_LEN=4) with a
// behavioural FIFO model; stats expectations follow FIFO_BURST_READER_STATS_EN.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic [31:0] stat_words;
    logic [31:0] stat_stall;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    int unsigned wp       = 0;
    int unsigned rp       = 0;
    int unsigned rd_total = 0;
    logic        flush    = 1'b0;

    logic [32:0] got_q [$];

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_W   (32),
        .BURST_LEN(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .stat_words  (stat_words),
        .stat_stall  (stat_stall)
    );

    // FIFO model: one-cycle registered read latency
    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (flush) begin
            rp <= wp;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rp[7:0]];
            rp           <= rp + 1;
            rd_total     <= rd_total + 1;
        end
    end

    task automatic step(input logic rdy);
        m_ready = rdy;
        if (m_valid && rdy)
            got_q.push_back({m_last, m_data});
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        mem[wp[7:0]] = d;
        wp = wp + 1;
    endtask

    task automatic fifo_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        en = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!busy)
                break;
            step(1'b1);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        en      = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_m_valid got=%b exp=0", m_valid);
        end
        checks++;
        if (m_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_m_last got=%b exp=0", m_last);
        end
        checks++;
        if (m_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_m_data got=%h exp=0", m_data);
        end
        checks++;
        if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rd_en=%b busy=%b exp=0 0", fifo_rd_en, busy);
        end
        checks++;
        if (stat_words !== 32'h0 || stat_stall !== 32'h0) begin
            failures++;
            $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_words, stat_stall);
        end
        rst = 1'b0;
        step(1'b0);
    endtask

    task automatic test_stream();
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_l;
        got_q.delete();
        for (int i = 0; i < 8; i++)
            push_word(32'h10 + i);
        en = 1'b1;
        step(1'b1);
        // n counts edges since en was sampled; data appears after edge 2
        for (int n = 0; n < 12; n++) begin
            exp_v = (n >= 2 && n <= 9);
            exp_d = 32'h10 + 32'(n - 2);
            exp_l = (n == 5 || n == 9);
            checks++;
            if (m_valid !== exp_v) begin
                failures++;
                $display("FAIL stream_valid n=%0d got=%b exp=%b", n, m_valid, exp_v);
            end else if (exp_v && (m_data !== exp_d || m_last !== exp_l)) begin
                failures++;
                $display("FAIL stream_word n=%0d got=%h/%b exp=%h/%b",
                         n, m_data, m_last, exp_d, exp_l);
            end
            step(1'b1);
        end
        drain();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_stop();
        fifo_flush();
        got_q.delete();
        for (int i = 0; i < 8; i++)
            push_word(32'h10 + i);
        en = 1'b1;
        step(1'b1);
        for (int n = 0; n < 30; n++) begin
            if (!busy)
                break;
            if (got_q.size() >= 2)
                en = 1'b0;
            step(1'b1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle got busy=%b exp=0", busy);
        end
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL stop_count got=%0d exp=4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== {(i == 3), 32'h10 + 32'(i)}) begin
                    failures++;
                    $display("FAIL stop_word i=%0d got=%h exp=%h",
                             i, got_q[i], {(i == 3), 32'h10 + 32'(i)});
                end
            end
        end
        checks++;
        if (wp - rp != 4 || mem[rp[7:0]] !== 32'h14) begin
            failures++;
            $display("FAIL stop_fifo_left got=%0d head=%h exp=4 head=14",
                     wp - rp, mem[rp[7:0]]);
        end
    endtask

    task automatic test_backpressure();
        logic        prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        logic        rdy;
        int          rd0;
        int          n;
        fifo_flush();
        got_q.delete();
        for (int i = 0; i < 8; i++)
            push_word(32'h30 + i);
        rd0        = int'(rd_total);
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        en         = 1'b1;
        n          = 0;
        while (got_q.size() < 8 && n < 80) begin
            rdy = (n % 3 == 0);
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l) begin
                    failures++;
                    $display("FAIL bp_hold n=%0d got=%b/%h/%b exp=1/%h/%b",
                             n, m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            checks++;
            if (int'(rd_total) - rd0 - got_q.size() > 2) begin
                failures++;
                $display("FAIL bp_occupancy n=%0d got=%0d exp<=2",
                         n, int'(rd_total) - rd0 - got_q.size());
            end
            prev_stall = m_valid && !rdy;
            prev_d     = m_data;
            prev_l     = m_last;
            step(rdy);
            n++;
        end
        drain();
        checks++;
        if (got_q.size() != 8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_count got=%0d busy=%b exp=8 busy=0", got_q.size(), busy);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== {(i == 3 || i == 7), 32'h30 + 32'(i)}) begin
                    failures++;
                    $display("FAIL bp_word i=%0d got=%h exp=%h",
                             i, got_q[i], {(i == 3 || i == 7), 32'h30 + 32'(i)});
                end
            end
        end
    endtask

    task automatic test_empty_gap();
        fifo_flush();
        got_q.delete();
        push_word(32'h20);
        push_word(32'h21);
        en = 1'b1;
        step(1'b1);
        for (int n = 0; n < 20; n++) begin
            if (n == 5) begin
                push_word(32'h22);
                push_word(32'h23);
                checks++;
                if (m_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_valid n=5 got=%b exp=0", m_valid);
                end
            end
            if (n == 7) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 32'h22) begin
                    failures++;
                    $display("FAIL gap_resume got=%b/%h exp=1/22", m_valid, m_data);
                end
            end
            if (got_q.size() >= 4)
                en = 1'b0;
            step(1'b1);
        end
        checks++;
        if (got_q.size() != 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL gap_count got=%0d busy=%b exp=4 busy=0", got_q.size(), busy);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== {(i == 3), 32'h20 + 32'(i)}) begin
                    failures++;
                    $display("FAIL gap_word i=%0d got=%h exp=%h",
                             i, got_q[i], {(i == 3), 32'h20 + 32'(i)});
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        fifo_flush();
        got_q.delete();
        for (int i = 0; i < 8; i++)
            push_word(32'h40 + i);
        en = 1'b1;
        repeat (4) step(1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h41) begin
            failures++;
            $display("FAIL rst_pre got=%b/%h exp=1/41", m_valid, m_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_clear got v=%b busy=%b rd_en=%b exp=0 0 0",
                     m_valid, busy, fifo_rd_en);
        end
        step(1'b1);
        rst = 1'b0;
        en  = 1'b0;
        fifo_flush();
        got_q.delete();
        for (int i = 0; i < 4; i++)
            push_word(32'h50 + i);
        en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (got_q.size() >= 4)
                en = 1'b0;
            step(1'b1);
        end
        checks++;
        if (got_q.size() != 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_after_count got=%0d busy=%b exp=4 busy=0", got_q.size(), busy);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== {(i == 3), 32'h50 + 32'(i)}) begin
                    failures++;
                    $display("FAIL rst_after_word i=%0d got=%h exp=%h",
                             i, got_q[i], {(i == 3), 32'h50 + 32'(i)});
                end
            end
        end
    endtask

    task automatic test_stats();
        int          stalls_left;
        int          n;
        logic        rdy;
        logic [31:0] exp_w;
        logic [31:0] exp_s;
`ifdef FIFO_BURST_READER_STATS_EN
        exp_w = 32'd8;
        exp_s = 32'd3;
`else
        exp_w = 32'd0;
        exp_s = 32'd0;
`endif
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        fifo_flush();
        got_q.delete();
        for (int i = 0; i < 8; i++)
            push_word(32'h60 + i);
        en          = 1'b1;
        stalls_left = 3;
        n           = 0;
        while (got_q.size() < 8 && n < 60) begin
            rdy = !(m_valid && stalls_left > 0);
            if (!rdy)
                stalls_left--;
            step(rdy);
            n++;
        end
        drain();
        checks++;
        if (got_q.size() != 8 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stats_count got=%0d busy=%b exp=8 busy=0", got_q.size(), busy);
        end
        checks++;
        if (stat_words !== exp_w) begin
            failures++;
            $display("FAIL stat_words got=%0d exp=%0d", stat_words, exp_w);
        end
        checks++;
        if (stat_stall !== exp_s) begin
            failures++;
            $display("FAIL stat_stall got=%0d exp=%0d", stat_stall, exp_s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stop();
        test_backpressure();
        test_empty_gap();
        test_reset_mid_burst();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer-side engine for the synchronous FIFO. Drives the FIFO read port (rd_en / rd_data / empty, 1-cycle registered read latency) and re-presents the words as a valid/ready stream.
- Groups words into fixed-length bursts with a last marker.
- A 2-entry output buffer absorbs FIFO read latency so the stream sustains 1 word/cycle.
- Start/stop control acts only at burst boundaries, so a stop never truncates a burst.

Parameters:
- DATA_W, 32: word width; must match the FIFO.
- BURST_LEN, 4: words per burst; must be >= 1. Counter width is max(1, $clog2(BURST_LEN)).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  run request; sampled at burst boundaries.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop request.
- fifo_rd_data  input  DATA_W  FIFO read data; valid the cycle after an accepted pop.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_W  stream word.
- m_last  output  1  last word of burst.
- busy  output  1  state != IDLE.
- stat_words  output  32  accepted-word counter (see Optional Feature).
- stat_stall  output  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state IDLE; buffer empty (count=0); inflight=0; issue_cnt=0; beat_cnt=0. Outputs m_valid=0, m_last=0, m_data=0, fifo_rd_en=0, busy=0, stat_*=0.
- pop = m_valid && m_ready. The head word leaves the buffer on pop.
- inflight: registered fifo_rd_en. When inflight=1, fifo_rd_data is written into the buffer this cycle.
- Buffer:
  - 2-entry FIFO, count 0..2, m_data = head entry, m_valid = (count != 0).
  - Push and pop in the same cycle leave count unchanged.
  - Push while count=2 without pop is a design error; flag it with a simulation assertion.
- Issue rule: fifo_rd_en = (state==ACTIVE) && !fifo_empty && (count + inflight - pop < 2) && !(issue_cnt==0 && !en).
  - This creates a combinational path m_ready -> fifo_rd_en; this path is intended.
- issue_cnt: increments on fifo_rd_en and wraps BURST_LEN-1 -> 0. issue_cnt==0 marks a burst boundary on the read side.
- beat_cnt: increments on pop and wraps BURST_LEN-1 -> 0.
- m_last = m_valid && (beat_cnt == BURST_LEN-1). With BURST_LEN=1, m_last = m_valid.
- FSM:
  - IDLE: no reads. en=1 -> ACTIVE.
  - ACTIVE: reads per the issue rule. issue_cnt==0 && en==0 -> DRAIN. A stop request mid-burst keeps issuing until the burst's BURST_LEN reads are issued.
  - DRAIN: no reads. Stream out the buffered/in-flight words. When count==0 && inflight==0 (after any same-cycle pop/push) -> IDLE.
  - en rising during DRAIN is ignored until IDLE is reached.
- Latency: first word is on m_data 2 cycles after en=1 while in IDLE with the FIFO non-empty (1 cycle to ACTIVE plus the read, 1 cycle FIFO latency).
- Sustained throughput: 1 word/cycle with m_ready=1 and the FIFO non-empty.
- FIFO empty mid-burst: reads pause and m_valid drops once the buffer is empty. beat_cnt holds; the burst resumes when data returns. No timeout.
- m_valid, m_data and m_last are stable while m_valid && !m_ready.
- Reset mid-burst: all state is cleared immediately; the partial burst is lost. FIFO contents are the FIFO's responsibility.

Optional Feature:
- Macro FIFO_BURST_READER_STATS_EN.
- Defined:
  - stat_words increments on every pop.
  - stat_stall increments on every cycle with m_valid && !m_ready.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: stat_words and stat_stall are tied to 0 and no counter flops are built. Port list is identical in both builds.

Test Plan (DATA_W=32, BURST_LEN=4):
1. FIFO preloaded with 0x10..0x17, m_ready=1, en pulsed high at cycle 0 and held -> m_data 0x10..0x17 on 8 consecutive cycles starting cycle 2; m_last on 0x13 and 0x17.
2. As test 1, but en dropped after 2 words accepted -> exactly 0x10..0x13 delivered, m_last on 0x13; state returns to IDLE; 0x14..0x17 remain in the FIFO; busy=0.
3. Backpressure: m_ready toggles 1,0,0,1,... -> no word lost or duplicated; fifo_rd_en never raises buffer count above 2; data held stable while stalled.
4. FIFO empty after 0x20,0x21 mid-burst; 0x22,0x23 written 5 cycles later -> m_valid gap; m_last only on 0x23.
5. rst asserted while m_valid=1 mid-burst -> next cycle m_valid=0, busy=0, fifo_rd_en=0; a new burst after reset starts with beat_cnt=0.
6. FIFO_BURST_READER_STATS_EN defined, 8 words with 3 stalled cycles -> stat_words=8, stat_stall=3. Macro undefined -> both read 0.
